// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM state type,
// opcode values, ALU operation codes and datapath mux encodings.
// Optional feature macro: MC_CONTROLLER_JUMP_EN (adds the j instruction).
package mips_pkg;

  // Controller states; JUMP exists only when the jump feature is built in.
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEXEC,
    S_ADDIWB
`ifdef MC_CONTROLLER_JUMP_EN
    , S_JUMP
`endif
  } state_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation requests to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True when the opcode is decoded by this build of the controller.
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
         (op == OP_BEQ) || (op == OP_ADDI);
`ifdef MC_CONTROLLER_JUMP_EN
    ok = ok || (op == OP_J);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM. Sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and mux selects, stalls on memory via mem_ready and
// counts retired instructions.
// Optional feature macro: MC_CONTROLLER_JUMP_EN (adds the JUMP state for op 000010;
// without it that opcode is reported as illegal).
module mc_controller
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             branch,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             retire,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register; reset returns to FETCH and drops any in-flight access.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state selection; mem_ready only matters in the memory-access states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
`ifdef MC_CONTROLLER_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
`ifdef MC_CONTROLLER_JUMP_EN
      S_JUMP:     state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore control outputs per state, with mem_ready gating the FETCH loads and
  // the store retire; everything is held at 0 while reset is asserted.
  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc      = PCSRC_ALU;
    alusrca    = 1'b0;
    alusrcb    = ALUSRCB_RT;
    aluop      = ALUOP_ADD;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    retire     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = ALUSRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = ALUSRCB_IMMSH;
        illegal_op = !op_supported(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        retire   = mem_ready;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        pcsrc   = PCSRC_ALUOUT;
        retire  = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
`ifdef MC_CONTROLLER_JUMP_EN
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        retire  = 1'b1;
      end
`endif
      default: ;
    endcase
    if (!reset_n) begin
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      pcsrc      = PCSRC_ALU;
      alusrca    = 1'b0;
      alusrcb    = ALUSRCB_RT;
      aluop      = ALUOP_ADD;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      retire     = 1'b0;
      illegal_op = 1'b0;
    end
  end

  // Retired-instruction count, wrapping naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register; the new value is visible the cycle after retire.
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instruction sequences plus
// randomized instructions and memory wait states, compared cycle by cycle
// against a per-instruction expected control-word schedule.
module tb_mc_controller;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [5:0]       op;
  logic             mem_ready;
  logic             mem_req, memwrite, iord, irwrite, pcwrite, branch;
  logic [1:0]       pcsrc, alusrcb, aluop;
  logic             alusrca, regdst, memtoreg, regwrite, retire, illegal_op;
  logic [CNT_W-1:0] instr_count;

  int nchecks = 0;
  int nerr    = 0;
  int exp_cnt = 0;

  mc_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .retire(retire), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Observed control word, field order matches cw() below.
  logic [17:0] act;
  assign act = {mem_req, memwrite, iord, irwrite, pcwrite, branch, pcsrc, alusrca,
                alusrcb, aluop, regdst, memtoreg, regwrite, retire, illegal_op};

  function automatic logic [17:0] cw(
      input logic mr, mw, io, irw, pcw, br, input logic [1:0] ps,
      input logic asa, input logic [1:0] asb, input logic [1:0] ao,
      input logic rd, m2r, rw, ret, ill);
    return {mr, mw, io, irw, pcw, br, ps, asa, asb, ao, rd, m2r, rw, ret, ill};
  endfunction

  // Expected instruction-count value as the counter width sees it.
  function automatic logic [CNT_W-1:0] cnt_exp();
    int v;
    v = exp_cnt % (1 << CNT_W);
    return v[CNT_W-1:0];
  endfunction

  // One clock cycle: drive mem_ready, check outputs mid-cycle, advance.
  task automatic step(input logic rdy, input logic [17:0] exp, input string tag);
    mem_ready = rdy;
    @(negedge clk);
    nchecks++;
    assert (act === exp) else begin
      nerr++;
      $error("FAIL %s ctl got=%h exp=%h", tag, act, exp);
    end
    nchecks++;
    assert (instr_count === cnt_exp()) else begin
      nerr++;
      $error("FAIL %s count got=%0d exp=%0d", tag, instr_count, cnt_exp());
    end
    @(posedge clk); #1;
    if (exp[1]) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Run one instruction through the controller: fw FETCH wait cycles and mw
  // wait cycles on its data access (if any).
  task automatic run_instr(input logic [5:0] o, input int fw, input int mw);
    logic [17:0] fetch_w, fetch_r, dec, madr, mrd, mwr;
    logic jump_ok;
    fetch_w = cw(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0,0);
    fetch_r = cw(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0,0,0);
    dec     = cw(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0,0);
    madr    = cw(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0);
    mrd     = cw(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0);
    mwr     = cw(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0);
`ifdef MC_CONTROLLER_JUMP_EN
    jump_ok = 1'b1;
`else
    jump_ok = 1'b0;
`endif
    op = 6'($urandom);
    for (int i = 0; i < fw; i++) step(1'b0, fetch_w, "fetch_wait");
    step(1'b1, fetch_r, "fetch");
    op = o;
    if (o == 6'b100011) begin
      step(rnd_bit(), dec, "lw_decode");
      step(rnd_bit(), madr, "lw_memadr");
      for (int i = 0; i < mw; i++) step(1'b0, mrd, "lw_memrd_wait");
      step(1'b1, mrd, "lw_memrd");
      step(rnd_bit(), cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1,1,0), "lw_wb");
    end else if (o == 6'b101011) begin
      step(rnd_bit(), dec, "sw_decode");
      step(rnd_bit(), madr, "sw_memadr");
      for (int i = 0; i < mw; i++) step(1'b0, mwr, "sw_memwr_wait");
      step(1'b1, mwr | 18'b10, "sw_memwr");
    end else if (o == 6'b000000) begin
      step(rnd_bit(), dec, "r_decode");
      step(rnd_bit(), cw(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0,0), "r_exec");
      step(rnd_bit(), cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,1,0), "r_wb");
    end else if (o == 6'b000100) begin
      step(rnd_bit(), dec, "beq_decode");
      step(rnd_bit(), cw(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,1,0), "beq_branch");
    end else if (o == 6'b001000) begin
      step(rnd_bit(), dec, "addi_decode");
      step(rnd_bit(), cw(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0), "addi_exec");
      step(rnd_bit(), cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1,1,0), "addi_wb");
    end else if (o == 6'b000010 && jump_ok) begin
      step(rnd_bit(), dec, "j_decode");
      step(rnd_bit(), cw(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,1,0), "j_jump");
    end else begin
      step(rnd_bit(), dec | 18'b1, "illegal_decode");
    end
  endtask

  logic [5:0] ops [8];

  initial begin
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b111111; ops[7] = 6'b000000;

    // Reset: outputs forced low, counter cleared.
    reset_n = 1'b0; mem_ready = 1'b1; op = 6'b100011;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nchecks++;
      assert (act === 18'h0) else begin
        nerr++; $error("FAIL reset_outputs got=%h exp=%h", act, 18'h0);
      end
      nchecks++;
      assert (instr_count === 4'd0) else begin
        nerr++; $error("FAIL reset_count got=%0d exp=0", instr_count);
      end
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    exp_cnt = 0;

    // Directed instructions.
    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b100011, 2, 2);

    // Randomized instruction mix with random wait states.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] o;
      o = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) o = 6'($urandom);
      run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset in the middle of a stalled load: no retire, counter cleared.
    op = 6'b100011;
    step(1'b1, cw(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0,0,0), "mid_fetch");
    step(1'b1, cw(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0,0), "mid_decode");
    step(1'b1, cw(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0), "mid_memadr");
    step(1'b0, cw(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0), "mid_memrd_wait");
    reset_n = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    nchecks++;
    assert (act === 18'h0) else begin
      nerr++; $error("FAIL midreset_outputs got=%h exp=%h", act, 18'h0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_cnt = 0;
    nchecks++;
    assert (instr_count === 4'd0) else begin
      nerr++; $error("FAIL midreset_count got=%0d exp=0", instr_count);
    end

    // Counter wrap: 16 addi instructions bring the 4-bit count back to 0.
    for (int n = 0; n < 16; n++) run_instr(6'b001000, $urandom_range(0, 1), 0);
    nchecks++;
    assert (instr_count === 4'd0) else begin
      nerr++; $error("FAIL wrap_count got=%0d exp=0", instr_count);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
